// File: rtl/hack_uart_loader_if.sv
// Loader-side bundle: UART receive line in, ROM write port and CPU control out.
interface hack_uart_loader_if #(
    parameter int unsigned ROM_AW = 15
);
    logic              uart_rxd;
    logic              rom_we;
    logic [ROM_AW-1:0] rom_waddr;
    logic [15:0]       rom_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    modport master (
        input  uart_rxd,
        output rom_we, rom_waddr, rom_wdata, cpu_hold, load_done, load_err
    );

    modport slave (
        output uart_rxd,
        input  rom_we, rom_waddr, rom_wdata, cpu_hold, load_done, load_err
    );
endinterface

// File: rtl/hack_uart_loader.sv
// UART (8N1) program loader: receives SYNC, LEN_H, LEN_L, N x {HI, LO} and writes
// each word into instruction ROM while holding the Hack CPU in reset.
module hack_uart_loader #(
    parameter int unsigned CLK_FREQ    = 25_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned ROM_AW      = 15,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 2_500_000
) (
    input logic                clk,
    input logic                rst_n,
    hack_uart_loader_if.master bus
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TO_W         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [16:0]      MAX_WORDS = 17'(2 ** ROM_AW);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, LEN_H, LEN_L, DATA_H, DATA_L, DONE, ERR} ld_state_t;

    rx_state_t        rx_state, rx_next;
    logic             rx_meta, rx_sync;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             byte_valid, frame_err;
    logic             tick_half, tick_bit;

    assign tick_half = (rx_cnt == HALF_LAST);
    assign tick_bit  = (rx_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) rx_state <= R_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  if (!rx_sync) rx_next = R_START;
            R_START: if (tick_half) rx_next = rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (tick_bit && rx_bit == 3'd7) rx_next = R_STOP;
            R_STOP:  if (tick_bit) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= bus.uart_rxd;
            rx_sync    <= rx_meta;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            rx_cnt     <= rx_cnt + 1'b1;
            case (rx_state)
                R_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end
                R_START: if (tick_half) rx_cnt <= '0;
                R_DATA: if (tick_bit) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_sync, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 1'b1;
                end
                R_STOP: if (tick_bit) begin
                    rx_cnt     <= '0;
                    byte_valid <= rx_sync;
                    frame_err  <= !rx_sync;
                end
                default: rx_cnt <= '0;
            endcase
        end
    end

    ld_state_t         state, state_next;
    logic [7:0]        len_hi, data_hi;
    logic [15:0]       n_words, n_written;
    logic [16:0]       rx_len;
    logic [TO_W-1:0]   to_cnt;
    logic              in_frame, timeout;
    logic              rom_we, cpu_hold;
    logic [ROM_AW-1:0] rom_waddr;
    logic [15:0]       rom_wdata;

    assign rx_len   = {1'b0, len_hi, rx_shift};
    assign in_frame = state inside {LEN_H, LEN_L, DATA_H, DATA_L};
    // A byte arriving in the same cycle as the deadline cancels the timeout.
    assign timeout  = in_frame && !byte_valid && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ERR: if (byte_valid && rx_shift == SYNC_BYTE) state_next = LEN_H;
            DONE:      state_next = IDLE;
            default: begin
                if (frame_err || timeout) state_next = ERR;
                else if (byte_valid) begin
                    case (state)
                        LEN_H:   state_next = LEN_L;
                        LEN_L: begin
                            if (rx_len == '0)            state_next = DONE;
                            else if (rx_len > MAX_WORDS) state_next = ERR;
                            else                         state_next = DATA_H;
                        end
                        DATA_H:  state_next = DATA_L;
                        DATA_L:  state_next = (n_written + 16'd1 == n_words) ? DONE : DATA_H;
                        default: state_next = ERR;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_we    <= 1'b0;
            rom_waddr <= '0;
            rom_wdata <= '0;
            cpu_hold  <= 1'b0;
            len_hi    <= '0;
            data_hi   <= '0;
            n_words   <= '0;
            n_written <= '0;
            to_cnt    <= '0;
        end else begin
            rom_we <= 1'b0;
            to_cnt <= (in_frame && !byte_valid) ? to_cnt + 1'b1 : '0;
            // Address advances after the strobe, except past the final word.
            if (rom_we && n_written != n_words) rom_waddr <= rom_waddr + 1'b1;
            if (byte_valid) begin
                case (state)
                    IDLE, ERR: if (rx_shift == SYNC_BYTE) begin
                        cpu_hold  <= 1'b1;
                        rom_waddr <= '0;
                        n_written <= '0;
                    end
                    LEN_H:  len_hi  <= rx_shift;
                    LEN_L:  n_words <= rx_len[15:0];
                    DATA_H: data_hi <= rx_shift;
                    DATA_L: begin
                        rom_we    <= 1'b1;
                        rom_wdata <= {data_hi, rx_shift};
                        n_written <= n_written + 16'd1;
                    end
                    default: ;
                endcase
            end
            if (state == DONE) cpu_hold <= 1'b0;
        end
    end

    always_comb begin
        bus.rom_we    = rom_we;
        bus.rom_waddr = rom_waddr;
        bus.rom_wdata = rom_wdata;
        bus.cpu_hold  = cpu_hold;
        bus.load_done = (state == DONE);
        bus.load_err  = (state == ERR);
    end
endmodule

// File: tb/tb_hack_uart_loader.sv
// Directed bench for hack_uart_loader: 10 clocks per bit, 16-word ROM, 1000-cycle timeout.
module tb_hack_uart_loader;
    localparam int unsigned BIT = 10;
    localparam int unsigned TO  = 1000;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [3:0]  w_addr[$];
    logic [15:0] w_data[$];
    int unsigned done_count = 0;
    logic        hold_at_done = 1'b0;

    hack_uart_loader_if #(.ROM_AW(4)) bus ();

    hack_uart_loader #(
        .CLK_FREQ(1_000_000),
        .BAUD(100_000),
        .ROM_AW(4),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rom_we) begin
            w_addr.push_back(bus.rom_waddr);
            w_data.push_back(bus.rom_wdata);
        end
        if (bus.load_done) begin
            done_count++;
            hold_at_done = bus.cpu_hold;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.uart_rxd = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rxd = b[i];
            tick(BIT);
        end
        bus.uart_rxd = stop;
        tick(BIT);
        bus.uart_rxd = 1'b1;
        tick(5);
    endtask

    task automatic send_seq(input byte_q_t q);
        foreach (q[i]) send_byte(q[i], 1'b1);
    endtask

    initial begin
        byte_q_t seq;
        int unsigned wb;
        int unsigned db;

        bus.uart_rxd = 1'b1;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        sample();
        check("rst_we", bus.rom_we, 0);
        check("rst_waddr", bus.rom_waddr, 0);
        check("rst_wdata", bus.rom_wdata, 0);
        check("rst_hold", bus.cpu_hold, 0);
        check("rst_done", bus.load_done, 0);
        check("rst_err", bus.load_err, 0);

        // 1: two-word frame
        wb = w_addr.size();
        db = done_count;
        send_byte(8'hA5, 1'b1);
        sample();
        check("t1_hold_after_sync", bus.cpu_hold, 1);
        seq = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_seq(seq);
        sample();
        check("t1_nwrites", w_addr.size() - wb, 2);
        check("t1_addr0", w_addr[wb], 0);
        check("t1_data0", w_data[wb], 16'h1234);
        check("t1_addr1", w_addr[wb+1], 1);
        check("t1_data1", w_data[wb+1], 16'hABCD);
        check("t1_done_cycles", done_count - db, 1);
        check("t1_hold_at_done", hold_at_done, 1);
        check("t1_hold_end", bus.cpu_hold, 0);
        check("t1_err", bus.load_err, 0);

        // 2: junk ignored in IDLE, then N==0 frame
        wb = w_addr.size();
        db = done_count;
        seq = '{8'h00, 8'hFF};
        send_seq(seq);
        sample();
        check("t2_junk_hold", bus.cpu_hold, 0);
        check("t2_junk_done", done_count - db, 0);
        hold_at_done = 1'b0;
        seq = '{8'hA5, 8'h00, 8'h00};
        send_seq(seq);
        sample();
        check("t2_nwrites", w_addr.size() - wb, 0);
        check("t2_done_cycles", done_count - db, 1);
        check("t2_hold_at_done", hold_at_done, 1);
        check("t2_hold_end", bus.cpu_hold, 0);

        // 3: timeout inside DATA_L, then recovery from ERR
        seq = '{8'hA5, 8'h00, 8'h01, 8'h12};
        send_seq(seq);
        tick(TO - 50);
        sample();
        check("t3_err_before_timeout", bus.load_err, 0);
        tick(60);
        sample();
        check("t3_err_after_timeout", bus.load_err, 1);
        check("t3_hold_in_err", bus.cpu_hold, 1);
        wb = w_addr.size();
        db = done_count;
        send_byte(8'hA5, 1'b1);
        sample();
        check("t3_err_cleared", bus.load_err, 0);
        check("t3_waddr_cleared", bus.rom_waddr, 0);
        seq = '{8'h00, 8'h01, 8'hAA, 8'h55};
        send_seq(seq);
        sample();
        check("t3_nwrites", w_addr.size() - wb, 1);
        check("t3_addr0", w_addr[wb], 0);
        check("t3_data0", w_data[wb], 16'hAA55);
        check("t3_done_cycles", done_count - db, 1);
        check("t3_hold_end", bus.cpu_hold, 0);

        // 4: framing error mid-frame
        wb = w_addr.size();
        seq = '{8'hA5, 8'h00, 8'h02, 8'h12};
        send_seq(seq);
        send_byte(8'h34, 1'b0);
        tick(20);
        sample();
        check("t4_err", bus.load_err, 1);
        check("t4_hold", bus.cpu_hold, 1);
        check("t4_nwrites", w_addr.size() - wb, 0);

        // 5: short low glitch between SYNC and LEN_H must not become a byte
        wb = w_addr.size();
        db = done_count;
        send_byte(8'hA5, 1'b1);
        bus.uart_rxd = 1'b0;
        tick(3);
        bus.uart_rxd = 1'b1;
        tick(150);
        seq = '{8'h00, 8'h01, 8'hBE, 8'hEF};
        send_seq(seq);
        sample();
        check("t5_err", bus.load_err, 0);
        check("t5_nwrites", w_addr.size() - wb, 1);
        check("t5_data0", w_data[wb], 16'hBEEF);
        check("t5_done_cycles", done_count - db, 1);

        // 6: reset in DATA_L, then a fresh frame writes from address 0
        seq = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
        send_seq(seq);
        sample();
        check("t6_waddr_before_rst", bus.rom_waddr, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        sample();
        check("t6_rst_we", bus.rom_we, 0);
        check("t6_rst_waddr", bus.rom_waddr, 0);
        check("t6_rst_wdata", bus.rom_wdata, 0);
        check("t6_rst_hold", bus.cpu_hold, 0);
        check("t6_rst_err", bus.load_err, 0);
        tick(10);
        wb = w_addr.size();
        db = done_count;
        seq = '{8'hA5, 8'h00, 8'h01, 8'h77, 8'h88};
        send_seq(seq);
        sample();
        check("t6_nwrites", w_addr.size() - wb, 1);
        check("t6_addr0", w_addr[wb], 0);
        check("t6_data0", w_data[wb], 16'h7788);
        check("t6_done_cycles", done_count - db, 1);

        // 7: N = 2**ROM_AW + 1 rejected, N = 2**ROM_AW accepted
        seq = '{8'hA5, 8'h00, 8'h11};
        send_seq(seq);
        sample();
        check("t7_oversize_err", bus.load_err, 1);
        check("t7_oversize_hold", bus.cpu_hold, 1);
        wb = w_addr.size();
        db = done_count;
        seq = '{8'hA5, 8'h00, 8'h10};
        for (int i = 0; i < 16; i++) begin
            seq.push_back(8'(i));
            seq.push_back(8'(i) ^ 8'h5A);
        end
        send_seq(seq);
        sample();
        check("t7_nwrites", w_addr.size() - wb, 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t7_addr%0d", i), w_addr[wb+i], i);
            check($sformatf("t7_data%0d", i), w_data[wb+i], {8'(i), 8'(i) ^ 8'h5A});
        end
        check("t7_last_waddr", bus.rom_waddr, 15);
        check("t7_done_cycles", done_count - db, 1);
        check("t7_err", bus.load_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
